// File: rtl/cpu_defines.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defines (package)
//  Description : Shared constants for param_cpu_core: opcodes, ALU operand
//                source selects and the run-control FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_defines;

    // Opcodes, carried in the top 4 bits of the instruction word
    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_HALT   = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_I  = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    // First ALU operand source
    localparam logic [1:0] SEL_A    = 2'd0;
    localparam logic [1:0] SEL_B    = 2'd1;
    localparam logic [1:0] SEL_ZERO = 2'd2;
    localparam logic [1:0] SEL_IN   = 2'd3;

    // Run-control FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_alu
//  Description : DATA_W-bit combinational adder with carry out.
//  Ports       : op0_i, op1_i  - operands
//                sum_o         - op0_i + op1_i (mod 2**DATA_W)
//                carry_o       - carry out of bit DATA_W-1
//  Revision    : 1.0  initial release
// ============================================================================
module cpu_alu #(
    parameter int DATA_W = 4
) (
    input  logic [DATA_W-1:0] op0_i,
    input  logic [DATA_W-1:0] op1_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              carry_o
);

    logic [DATA_W:0] w_full;

    assign w_full  = {1'b0, op0_i} + {1'b0, op1_i};
    assign sum_o   = w_full[DATA_W-1:0];
    assign carry_o = w_full[DATA_W];

endmodule
`default_nettype wire

// File: rtl/param_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : param_cpu_core
//  Description : Parametrised fetch/decode/execute core, one instruction per
//                executing clk_cpu cycle from a combinational ROM.
//  Ports       : clk_cpu, reset_n       - clock, async active-low reset
//                start, step            - run control (start has priority)
//                inst_adrs / inst_in    - instruction ROM address / word
//                in_port / out_port     - data input / registered output
//                halted, running        - FSM status
//                carry, reg_a, reg_b    - debug views of the datapath
//  Revision    : 1.0  initial release
// ============================================================================
module param_cpu_core
    import cpu_defines::*;
#(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic                clk_cpu,
    input  logic                reset_n,
    input  logic                start,
    input  logic                step,
    output logic [ADDR_W-1:0]   inst_adrs,
    input  logic [DATA_W+3:0]   inst_in,
    input  logic [DATA_W-1:0]   in_port,
    output logic [DATA_W-1:0]   out_port,
    output logic                halted,
    output logic                running,
    output logic                carry,
    output logic [DATA_W-1:0]   reg_a,
    output logic [DATA_W-1:0]   reg_b
);

    localparam int INST_W = 4 + DATA_W;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic              carry_q, carry_d;

    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_im;
    logic [1:0]        w_sel;
    logic              w_use_im, w_wr_a, w_wr_b, w_wr_out, w_halt, w_jump;
    logic [DATA_W-1:0] w_op0, w_op1, w_sum;
    logic              w_alu_c, w_exec;

    assign w_op = inst_in[INST_W-1:DATA_W];
    assign w_im = inst_in[DATA_W-1:0];

    // Decode. Every result goes through the adder: moves, IN and OUT add
    // zero, so carry is cleared by every instruction that is not an ADD.
    always_comb begin
        w_sel    = SEL_ZERO;
        w_use_im = 1'b0;
        w_wr_a   = 1'b0;
        w_wr_b   = 1'b0;
        w_wr_out = 1'b0;
        w_halt   = 1'b0;
        w_jump   = 1'b0;
        case (w_op)
            OP_ADD_A:  begin w_sel = SEL_A;  w_use_im = 1'b1; w_wr_a = 1'b1; end
            OP_MOV_AB: begin w_sel = SEL_B;  w_wr_a = 1'b1; end
            OP_IN_A:   begin w_sel = SEL_IN; w_wr_a = 1'b1; end
            OP_MOV_AI: begin w_use_im = 1'b1; w_wr_a = 1'b1; end
            OP_MOV_BA: begin w_sel = SEL_A;  w_wr_b = 1'b1; end
            OP_ADD_B:  begin w_sel = SEL_B;  w_use_im = 1'b1; w_wr_b = 1'b1; end
            OP_IN_B:   begin w_sel = SEL_IN; w_wr_b = 1'b1; end
            OP_MOV_BI: begin w_use_im = 1'b1; w_wr_b = 1'b1; end
            OP_HALT:   w_halt = 1'b1;
            OP_OUT_B:  begin w_sel = SEL_B;  w_wr_out = 1'b1; end
            OP_OUT_I:  begin w_use_im = 1'b1; w_wr_out = 1'b1; end
            OP_JNC:    w_jump = ~carry_q;
            OP_JMP:    w_jump = 1'b1;
            default:   ;
        endcase
    end

    always_comb begin
        case (w_sel)
            SEL_A:   w_op0 = a_q;
            SEL_B:   w_op0 = b_q;
            SEL_IN:  w_op0 = in_port;
            default: w_op0 = '0;
        endcase
    end

    assign w_op1 = w_use_im ? w_im : '0;

    cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .op0_i   (w_op0),
        .op1_i   (w_op1),
        .sum_o   (w_sum),
        .carry_o (w_alu_c)
    );

    assign w_exec = (state_q == ST_RUN) |
                    (((state_q == ST_IDLE) | (state_q == ST_HALTED)) & (start | step));

    // FSM: state register
    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM: next state. A single step returns to the state it came from.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (start) state_d = w_halt ? ST_HALTED : ST_RUN;
            end
            ST_RUN:  if (w_halt) state_d = ST_HALTED;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        halted  = 1'b0;
        running = 1'b0;
        case (state_q)
            ST_RUN:    running = 1'b1;
            ST_HALTED: halted  = 1'b1;
            default:   ;
        endcase
    end

    // Datapath next state
    always_comb begin
        pc_d    = pc_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        carry_d = carry_q;
        if (w_exec) begin
            pc_d    = w_jump ? w_im[ADDR_W-1:0] : pc_q + 1'b1;
            carry_d = w_alu_c;
            if (w_wr_a)   a_d   = w_sum;
            if (w_wr_b)   b_d   = w_sum;
            if (w_wr_out) out_d = w_sum;
        end
    end

    always_ff @(posedge clk_cpu or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            carry_q <= carry_d;
        end
    end

    assign inst_adrs = pc_q;
    assign out_port  = out_q;
    assign carry     = carry_q;
    assign reg_a     = a_q;
    assign reg_b     = b_q;

endmodule
`default_nettype wire

// File: tb/tb_param_cpu_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_cpu_core
//  Description : Self-checking bench for param_cpu_core, a 4/4 instance and
//                an 8/6 instance driven from bench-side ROM arrays.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_param_cpu_core;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------- 4-bit data / 4-bit address instance -----------------
    logic       rst4_n, start4, step4;
    logic [3:0] adrs4, in4, out4, a4, b4;
    logic [7:0] inst4;
    logic       h4, r4, c4;
    logic [7:0] rom4 [16];

    assign inst4 = rom4[adrs4];

    param_cpu_core #(.DATA_W(4), .ADDR_W(4)) u_dut4 (
        .clk_cpu(clk), .reset_n(rst4_n), .start(start4), .step(step4),
        .inst_adrs(adrs4), .inst_in(inst4), .in_port(in4), .out_port(out4),
        .halted(h4), .running(r4), .carry(c4), .reg_a(a4), .reg_b(b4)
    );

    // ---------------- 8-bit data / 6-bit address instance -----------------
    logic        rst8_n, start8, step8;
    logic [5:0]  adrs8;
    logic [7:0]  in8, out8, a8, b8;
    logic [11:0] inst8;
    logic        h8, r8, c8;
    logic [11:0] rom8 [64];

    assign inst8 = rom8[adrs8];

    param_cpu_core #(.DATA_W(8), .ADDR_W(6)) u_dut8 (
        .clk_cpu(clk), .reset_n(rst8_n), .start(start8), .step(step8),
        .inst_adrs(adrs8), .inst_in(inst8), .in_port(in8), .out_port(out8),
        .halted(h8), .running(r8), .carry(c8), .reg_a(a8), .reg_b(b8)
    );

    typedef struct {
        logic       start;
        logic       step;
        logic [3:0] pc;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        logic [3:0] out;
        logic       h;
        logic       r;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock, then sample 1 ns after the rising edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk4(input string tag, input logic [3:0] pc, input logic [3:0] a,
                        input logic [3:0] b, input logic c, input logic [3:0] o,
                        input logic h, input logic r);
        chk({tag, ".pc"},      32'(adrs4), 32'(pc));
        chk({tag, ".a"},       32'(a4),    32'(a));
        chk({tag, ".b"},       32'(b4),    32'(b));
        chk({tag, ".carry"},   32'(c4),    32'(c));
        chk({tag, ".out"},     32'(out4),  32'(o));
        chk({tag, ".halted"},  32'(h4),    32'(h));
        chk({tag, ".running"}, 32'(r4),    32'(r));
    endtask

    task automatic reset4();
        start4 = 1'b0;
        step4  = 1'b0;
        @(negedge clk);
        rst4_n = 1'b0;
        @(negedge clk);
        rst4_n = 1'b1;
        #1;
    endtask

    initial begin
        rst4_n = 1'b1; start4 = 1'b0; step4 = 1'b0; in4 = 4'h0;
        rst8_n = 1'b1; start8 = 1'b0; step8 = 1'b0; in8 = 8'h00;
        for (int i = 0; i < 16; i++) rom4[i] = 8'h00;
        for (int i = 0; i < 64; i++) rom8[i] = 12'h000;

        // -------- Program 1: basic run, HALT, restart, carry and JNC ------
        rom4[0] = 8'h33;   // MOV A,3
        rom4[1] = 8'h05;   // ADD A,5
        rom4[2] = 8'hB9;   // OUT 9
        rom4[3] = 8'h80;   // HALT
        rom4[4] = 8'h32;   // MOV A,2
        rom4[5] = 8'h0F;   // ADD A,15  -> A=1, carry=1
        rom4[6] = 8'hE0;   // JNC 0     -> not taken, carry cleared
        rom4[7] = 8'hE0;   // JNC 0     -> taken

        //           start step  pc     a      b      c     out    h     r
        tbl[0] = '{1'b1, 1'b0, 4'd1, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b0, 4'd2, 4'd8, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 4'd3, 4'd8, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b0, 4'd4, 4'd8, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 4'd4, 4'd8, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 4'd5, 4'd2, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1};
        tbl[6] = '{1'b0, 1'b0, 4'd6, 4'd1, 4'd0, 1'b1, 4'd9, 1'b0, 1'b1};
        tbl[7] = '{1'b0, 1'b0, 4'd7, 4'd1, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b0, 4'd0, 4'd1, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b0, 4'd1, 4'd3, 4'd0, 1'b0, 4'd9, 1'b0, 1'b1};

        reset4();
        chk4("reset", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        for (int i = 0; i < 10; i++) begin
            start4 = tbl[i].start;
            step4  = tbl[i].step;
            cyc();
            chk4($sformatf("vec%0d", i), tbl[i].pc, tbl[i].a, tbl[i].b,
                 tbl[i].c, tbl[i].out, tbl[i].h, tbl[i].r);
        end
        start4 = 1'b0;
        step4  = 1'b0;

        // -------- Program 2: IN B / OUT B / JMP 0 loop, async reset ------
        for (int i = 0; i < 16; i++) rom4[i] = 8'h00;
        rom4[0] = 8'h60;   // IN B
        rom4[1] = 8'h90;   // OUT B
        rom4[2] = 8'hF0;   // JMP 0
        reset4();
        in4    = 4'hA;
        start4 = 1'b1;
        cyc();
        start4 = 1'b0;
        chk4("io1", 4'd1, 4'd0, 4'hA, 1'b0, 4'h0, 1'b0, 1'b1);
        cyc();
        chk4("io2", 4'd2, 4'd0, 4'hA, 1'b0, 4'hA, 1'b0, 1'b1);
        cyc();
        chk("io3.pc", 32'(adrs4), 32'd0);
        cyc();
        chk("io4.pc", 32'(adrs4), 32'd1);

        // Reset asserted between edges must clear everything at once
        #2;
        rst4_n = 1'b0;
        #1;
        chk4("async_rst", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst4_n = 1'b1;
        cyc();
        chk4("post_rst", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);

        // -------- Program 3: single stepping from IDLE --------------------
        for (int i = 0; i < 16; i++) rom4[i] = 8'h00;
        rom4[0] = 8'h31;   // MOV A,1
        rom4[1] = 8'h01;   // ADD A,1
        rom4[2] = 8'h40;   // MOV B,A
        reset4();
        step4 = 1'b1;
        cyc();
        step4 = 1'b0;
        chk4("step1", 4'd1, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc();
        cyc();
        chk4("idle_hold", 4'd1, 4'd1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        step4 = 1'b1;
        cyc();
        step4 = 1'b0;
        chk4("step2", 4'd2, 4'd2, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc();
        step4 = 1'b1;
        cyc();
        step4 = 1'b0;
        chk4("step3", 4'd3, 4'd2, 4'd2, 1'b0, 4'd0, 1'b0, 1'b0);
        cyc();
        chk("step_end.pc", 32'(adrs4), 32'd3);

        // -------- Wide instance: jump to top address and wrap -------------
        rom8[0]  = 12'hF3F;   // JMP 63
        rom8[63] = 12'h0FF;   // ADD A,0xFF
        @(negedge clk);
        rst8_n = 1'b0;
        @(negedge clk);
        rst8_n = 1'b1;
        #1;
        chk("w.reset.pc", 32'(adrs8), 32'd0);
        start8 = 1'b1;
        cyc();
        start8 = 1'b0;
        chk("w.jmp.pc",   32'(adrs8), 32'd63);
        chk("w.jmp.run",  32'(r8),    32'd1);
        cyc();
        chk("w.wrap.pc",  32'(adrs8), 32'd0);
        chk("w.wrap.a",   32'(a8),    32'hFF);
        chk("w.wrap.c",   32'(c8),    32'd0);
        chk("w.wrap.b",   32'(b8),    32'd0);
        chk("w.wrap.out", 32'(out8),  32'd0);
        chk("w.wrap.h",   32'(h8),    32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
